// File: rtl/lane_merge_pkg.sv
// Shared constants for the 2:1 lane recombiner: lane indices, default geometry
// and the width of the optional drop counter.
package lane_merge_pkg;

  localparam logic        LANE0         = 1'b0;
  localparam logic        LANE1         = 1'b1;
  localparam int unsigned DEF_WIDTH     = 1;
  localparam int unsigned DEF_DEPTH     = 4;
  localparam int unsigned DROP_CNT_W    = 8;

endpackage

// File: rtl/lane_merge_2to1_lane_fifo.sv
// Per-lane FIFO for lane_merge_2to1. Pushes arrive pre-qualified by the parent;
// head word is presented combinationally from the registered read pointer.
module lane_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_nxt;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/lane_merge_2to1.sv
// Re-interleaves the two demux lanes (lane 0 first) into one registered
// valid/ready stream. Define LANE_MERGE_DROP_CNT_EN to add the drop_cnt port.
module lane_merge_2to1
  import lane_merge_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      data_in0,
  input  logic                  valid_in0,
  input  logic [WIDTH-1:0]      data_in1,
  input  logic                  valid_in1,
  input  logic                  ready_in,
  output logic [WIDTH-1:0]      data_out,
  output logic                  valid_out,
  output logic                  full0,
  output logic                  full1,
`ifdef LANE_MERGE_DROP_CNT_EN
  output logic [DROP_CNT_W-1:0] drop_cnt,
`endif
  output logic                  overflow
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             sel;
  logic             pop_any, pop0, pop1;
  logic             acc0, acc1, drop0, drop1;
  logic             empty0, empty1;
  logic [CW-1:0]    count0, count1;
  logic [WIDTH-1:0] dout0, dout1;

  // A full lane may still accept a push when it is being drained that cycle.
  always_comb begin
    pop_any = ((sel == LANE0) ? !empty0 : !empty1) && (ready_in || !valid_out);
    pop0    = pop_any && (sel == LANE0);
    pop1    = pop_any && (sel == LANE1);
    acc0    = valid_in0 && ((count0 < CW'(DEPTH)) || pop0);
    acc1    = valid_in1 && ((count1 < CW'(DEPTH)) || pop1);
    drop0   = valid_in0 && !acc0;
    drop1   = valid_in1 && !acc1;
  end

  lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .reset (reset),
    .push  (acc0),
    .pop   (pop0),
    .din   (data_in0),
    .dout  (dout0),
    .count (count0),
    .full  (full0),
    .empty (empty0)
  );

  lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .reset (reset),
    .push  (acc1),
    .pop   (pop1),
    .din   (data_in1),
    .dout  (dout1),
    .count (count1),
    .full  (full1),
    .empty (empty1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      sel       <= LANE0;
      data_out  <= '0;
      valid_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (pop_any) begin
        data_out  <= (sel == LANE0) ? dout0 : dout1;
        valid_out <= 1'b1;
        sel       <= ~sel;
      end else if (ready_in) begin
        valid_out <= 1'b0;
      end
      if (drop0 || drop1) overflow <= 1'b1;
    end
  end

`ifdef LANE_MERGE_DROP_CNT_EN
  logic [DROP_CNT_W:0] drop_sum;

  always_comb begin
    drop_sum = {1'b0, drop_cnt} + (DROP_CNT_W + 1)'(drop0) + (DROP_CNT_W + 1)'(drop1);
  end

  always_ff @(posedge clk) begin
    if (reset) drop_cnt <= '0;
    else       drop_cnt <= drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
  end
`endif

endmodule

// File: tb/tb_lane_merge_2to1.sv
// Directed self-checking bench for lane_merge_2to1 (WIDTH=4, DEPTH=4).
module tb_lane_merge_2to1;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] data_in0, data_in1;
  logic       valid_in0, valid_in1, ready_in;
  logic [3:0] data_out;
  logic       valid_out, full0, full1, overflow;
`ifdef LANE_MERGE_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  lane_merge_2to1 #(.WIDTH(4), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in0  (data_in0),
    .valid_in0 (valid_in0),
    .data_in1  (data_in1),
    .valid_in1 (valid_in1),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .full0     (full0),
    .full1     (full1),
`ifdef LANE_MERGE_DROP_CNT_EN
    .drop_cnt  (drop_cnt),
`endif
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; valid_in0 = 1'b0; valid_in1 = 1'b0;
    data_in0 = '0; data_in1 = '0; ready_in = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_in0 = 1'b1; valid_in1 = 1'b1;
    data_in0 = 4'h5; data_in1 = 4'h6; ready_in = 1'b1;
    tick();
    reset = 1'b0; valid_in0 = 1'b0; valid_in1 = 1'b0;
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
    n_checks++; if (data_out !== 4'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", data_out); end
    n_checks++; if ({full0, full1, overflow} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {full0, full1, overflow}); end
`ifdef LANE_MERGE_DROP_CNT_EN
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
`endif
    tick();
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_push_ignored: got valid %b expected 0", valid_out); end
  endtask

  task automatic test_order();
    do_reset();
    valid_in0 = 1'b1; data_in0 = 4'h1; valid_in1 = 1'b1; data_in1 = 4'h0;
    tick();
    valid_in0 = 1'b0; valid_in1 = 1'b0;
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL order_no_bypass: got valid %b expected 0", valid_out); end
    tick();
    n_checks++; if ({valid_out, data_out} !== {1'b1, 4'h1}) begin n_fail++; $display("FAIL order_first: got v=%b d=%h expected v=1 d=1", valid_out, data_out); end
    tick();
    n_checks++; if ({valid_out, data_out} !== {1'b1, 4'h0}) begin n_fail++; $display("FAIL order_second: got v=%b d=%h expected v=1 d=0", valid_out, data_out); end
    tick();
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL order_end: got valid %b expected 0", valid_out); end
  endtask

  task automatic test_lane1_first();
    do_reset();
    valid_in1 = 1'b1; data_in1 = 4'h1;
    tick();
    valid_in1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL lane1_first_stall%0d: got valid %b expected 0", i, valid_out); end
      if (i == 2) begin valid_in0 = 1'b1; data_in0 = 4'h0; end
      tick();
    end
    valid_in0 = 1'b0;
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL lane1_first_latency: got valid %b expected 0", valid_out); end
    tick();
    n_checks++; if ({valid_out, data_out} !== {1'b1, 4'h0}) begin n_fail++; $display("FAIL lane1_first_w0: got v=%b d=%h expected v=1 d=0", valid_out, data_out); end
    tick();
    n_checks++; if ({valid_out, data_out} !== {1'b1, 4'h1}) begin n_fail++; $display("FAIL lane1_first_w1: got v=%b d=%h expected v=1 d=1", valid_out, data_out); end
  endtask

  task automatic test_overflow();
    do_reset();
    ready_in = 1'b0;
    valid_in0 = 1'b1; data_in0 = 4'h9;
    tick();
    valid_in0 = 1'b0;
    tick();
    n_checks++; if ({valid_out, data_out} !== {1'b1, 4'h9}) begin n_fail++; $display("FAIL ovf_preload: got v=%b d=%h expected v=1 d=9", valid_out, data_out); end
    for (int i = 0; i < 5; i++) begin
      valid_in0 = 1'b1; data_in0 = 4'(i + 10);
      tick();
      if (i == 3) begin
        n_checks++; if ({full0, overflow} !== 2'b10) begin n_fail++; $display("FAIL ovf_full_after4: got full0=%b ovf=%b expected 1 0", full0, overflow); end
      end
    end
    valid_in0 = 1'b0;
    n_checks++; if ({full0, overflow} !== 2'b11) begin n_fail++; $display("FAIL ovf_drop5: got full0=%b ovf=%b expected 1 1", full0, overflow); end
    n_checks++; if ({valid_out, data_out} !== {1'b1, 4'h9}) begin n_fail++; $display("FAIL ovf_hold: got v=%b d=%h expected v=1 d=9", valid_out, data_out); end
`ifdef LANE_MERGE_DROP_CNT_EN
    n_checks++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL ovf_drop_cnt: got %0d expected 1", drop_cnt); end
`endif
    tick();
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    ready_in = 1'b0;
    valid_in0 = 1'b1; data_in0 = 4'hA; valid_in1 = 1'b1; data_in1 = 4'hB;
    tick();
    valid_in1 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      data_in0 = 4'(i);
      tick();
    end
    valid_in0 = 1'b0;
    n_checks++; if ({full0, valid_out, data_out} !== {2'b11, 4'hA}) begin n_fail++; $display("FAIL fpp_setup: got full0=%b v=%b d=%h expected 1 1 a", full0, valid_out, data_out); end
    ready_in = 1'b1;
    tick();
    n_checks++; if ({full0, data_out} !== {1'b1, 4'hB}) begin n_fail++; $display("FAIL fpp_lane1: got full0=%b d=%h expected 1 b", full0, data_out); end
    valid_in0 = 1'b1; data_in0 = 4'h5;
    tick();
    valid_in0 = 1'b0; ready_in = 1'b0;
    n_checks++; if ({full0, overflow, data_out} !== {2'b10, 4'h1}) begin n_fail++; $display("FAIL fpp_push_pop: got full0=%b ovf=%b d=%h expected 1 0 1", full0, overflow, data_out); end
  endtask

  task automatic test_backpressure();
    int    idx;
    logic  held_v;
    logic [3:0] held_d;
    do_reset();
    idx = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      valid_in0 = (cyc < 4); valid_in1 = (cyc < 4);
      data_in0 = 4'(2 * cyc); data_in1 = 4'(2 * cyc + 1);
      ready_in = (cyc % 2 == 0);
      held_v = valid_out && !ready_in;
      held_d = data_out;
      if (valid_out && ready_in) begin
        n_checks++; if (data_out !== 4'(idx)) begin n_fail++; $display("FAIL bp_word%0d: got %h expected %h", idx, data_out, 4'(idx)); end
        idx++;
      end
      tick();
      if (held_v) begin
        n_checks++; if ({valid_out, data_out} !== {1'b1, held_d}) begin n_fail++; $display("FAIL bp_hold_cyc%0d: got v=%b d=%h expected v=1 d=%h", cyc, valid_out, data_out, held_d); end
      end
    end
    valid_in0 = 1'b0; valid_in1 = 1'b0;
    n_checks++; if (idx !== 8) begin n_fail++; $display("FAIL bp_count: got %0d words expected 8", idx); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    ready_in = 1'b0;
    valid_in0 = 1'b1; data_in0 = 4'h2; valid_in1 = 1'b1; data_in1 = 4'h3;
    tick();
    data_in0 = 4'h4; data_in1 = 4'h5;
    tick();
    valid_in0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_in1 = 4'(6 + i);
      tick();
    end
    valid_in1 = 1'b0;
    n_checks++; if ({full1, overflow, valid_out} !== 3'b111) begin n_fail++; $display("FAIL rmid_setup: got full1=%b ovf=%b v=%b expected 111", full1, overflow, valid_out); end
    reset = 1'b1; valid_in0 = 1'b1; data_in0 = 4'h9;
    tick();
    reset = 1'b0; valid_in0 = 1'b0;
    n_checks++; if ({valid_out, full0, full1, overflow, data_out} !== 8'h00) begin n_fail++; $display("FAIL rmid_cleared: got v=%b f0=%b f1=%b ovf=%b d=%h expected all 0", valid_out, full0, full1, overflow, data_out); end
    ready_in = 1'b1;
    valid_in0 = 1'b1; data_in0 = 4'hC; valid_in1 = 1'b1; data_in1 = 4'hD;
    tick();
    valid_in0 = 1'b0; valid_in1 = 1'b0;
    tick();
    n_checks++; if ({valid_out, data_out} !== {1'b1, 4'hC}) begin n_fail++; $display("FAIL rmid_first_out: got v=%b d=%h expected v=1 d=c", valid_out, data_out); end
    tick();
    n_checks++; if ({valid_out, data_out} !== {1'b1, 4'hD}) begin n_fail++; $display("FAIL rmid_second_out: got v=%b d=%h expected v=1 d=d", valid_out, data_out); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; valid_in0 = 1'b0; valid_in1 = 1'b0;
    data_in0 = '0; data_in1 = '0; ready_in = 1'b0;
    test_reset();
    test_order();
    test_lane1_first();
    test_overflow();
    test_full_push_pop();
    test_backpressure();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
